muldiv_ctrl: RTL
================

# muldiv_ctrl

Multi-cycle multiply/divide sequencer in the execute stage. It accepts MULT/MULTU/DIV/DIVU operations decoded in D and carried into E. It stalls the pipeline while the operation runs and delivers a one-cycle HI/LO write pulse with the 64-bit result. It owns the iterative radix-2 divider and the registered multiplier, and it aborts cleanly on exception flush.

## Interface
- DATA_W, 32: operand width; HI/LO are each DATA_W bits.
- DIV_ITER, DATA_W: divider iteration count, one quotient bit per cycle.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ismultE  in  1  multiply request
- signedmultE  in  1  1 = MULT, 0 = MULTU
- isdivE  in  1  divide request
- signeddivE  in  1  1 = DIV, 0 = DIVU
- srcaE  in  DATA_W  rs operand (multiplicand / dividend)
- srcbE  in  DATA_W  rt operand (multiplier / divisor)
- cancel  in  1  exception flush of E; aborts any operation
- stall_muldiv  out  1  to hazard unit; freezes F/D/E while high
- busy  out  1  state != IDLE
- hilo_we  out  1  one-cycle HI and LO write strobe
- hi_o  out  DATA_W  result HI (remainder / product[63:32])
- lo_o  out  DATA_W  result LO (quotient / product[31:0])

## Operation
- FSM states:
  - IDLE: waits for a request.
  - MULT: one cycle; the product is registered from the latched operands.
  - DIV: DIV_ITER cycles of restoring shift-subtract on magnitudes.
  - DONE: one cycle; hilo_we = 1, then IDLE.
- Accept: in IDLE with (ismultE | isdivE) & !cancel, latch operands and signedness. Divide wins if both requests are high.
- Multiply:
  - Signed: 64-bit two's-complement product of the sign-extended operands.
  - Unsigned: zero-extended product.
- Divide:
  - Operands are converted to magnitudes when signed.
  - Sign fix-up is applied on the last DIV iteration: quotient sign = sa ^ sb, remainder sign = sa.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo = 0x80000000, hi = 0 (wraps, no trap).
- Divide by zero: DIV is skipped; IDLE goes directly to DONE with hi = srcaE, lo = 0xFFFFFFFF, for signed and unsigned alike.
- Cancel:
  - In any state, the next edge goes to IDLE and latched data is discarded.
  - hilo_we is forced to 0 in the cancel cycle.
  - A request and cancel in the same IDLE cycle is not accepted.
- hi_o/lo_o hold the last completed result until the next DONE.
- Reset: state IDLE, hi_o = lo_o = 0, hilo_we = 0, busy = 0; stall_muldiv is forced to 0 while rst is high.

## Timing
- stall_muldiv = (IDLE & accept) | MULT | DIV; it is 0 in DONE so the instruction leaves E together with the write strobe.
- Multiply: accept at cycle N, stall in N and N+1, hilo_we at N+2.
- Divide: accept at N, stall N..N+DIV_ITER, hilo_we at N+DIV_ITER+1 (N+33 for 32 bits).
- Divide by zero: stall in N only, hilo_we at N+1.
- Back-to-back: a new request seen in the DONE cycle is not accepted. It is accepted in the following IDLE cycle, because the hazard unit re-presents it.
- Reset asserted mid-operation returns the block to IDLE asynchronously; no hilo_we is produced.

## Configuration
- MULDIV_EARLY_OUT_EN:
  - Defined: a divide with |dividend| < |divisor| (nonzero divisor) skips DIV and goes to DONE at N+1 with lo = 0, hi = the original signed dividend; stall is high in N only.
  - Undefined: every nonzero-divisor divide takes the full DIV_ITER cycles and produces the identical result.

## Structure
- defines.vh holds the state encodings (MD_IDLE, MD_MULT, MD_DIV, MD_DONE) and the DIV_ITER default next to the existing funct/op defines.
- Sub-module div_radix2 holds the remainder/quotient shift registers, the iteration counter and the sign fix-up. It has start, cancel and done handshake ports.
- muldiv_ctrl keeps the FSM, operand latches, the multiplier register, the special-case muxing and the stall/strobe generation.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 (signed): stall 2 cycles, hilo_we at N+2, hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; the same operands as MULTU give hi = 0x00000002, lo = 0xFFFFFFFA.
- DIV -7 / 2 (0xFFFFFFF9 / 0x00000002): hilo_we at N+33, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 100 / 7 gives lo = 14, hi = 2.
- DIVU 5 / 0: hilo_we at N+1, hi = 5, lo = 0xFFFFFFFF; signed 0x80000000 / -1 gives lo = 0x80000000, hi = 0.
- DIV started, cancel pulsed at N+10: IDLE at N+11, no hilo_we ever, hi_o/lo_o unchanged, stall low from N+11.
- With MULDIV_EARLY_OUT_EN: DIVU 3 / 10 gives hilo_we at N+1, lo = 0, hi = 3; without it, the same result at N+33.
- rst asserted at N+5 of a divide: busy = 0 and stall_muldiv = 0 immediately, hi_o = lo_o = 0; a MULT after release completes normally.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared state encoding and width defaults for the mul/div sequencer
package muldiv_ctrl_pkg;

  localparam int MD_DATA_W   = 32;
  localparam int MD_DIV_ITER = MD_DATA_W;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - E-stage request / HI-LO result bundle for the mul/div sequencer
interface muldiv_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              ismultE;
  logic              signedmultE;
  logic              isdivE;
  logic              signeddivE;
  logic [DATA_W-1:0] srcaE;
  logic [DATA_W-1:0] srcbE;
  logic              cancel;
  logic              stall_muldiv;
  logic              busy;
  logic              hilo_we;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output ismultE, signedmultE, isdivE, signeddivE, srcaE, srcbE, cancel,
    input  stall_muldiv, busy, hilo_we, hi_o, lo_o
  );

  modport slave (
    input  ismultE, signedmultE, isdivE, signeddivE, srcaE, srcbE, cancel,
    output stall_muldiv, busy, hilo_we, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl_div_radix2.sv
// rtl/muldiv_ctrl_div_radix2.sv - restoring radix-2 divider on magnitudes, one quotient bit per cycle
module div_radix2
  import muldiv_ctrl_pkg::*;
#(
  parameter int W    = MD_DATA_W,
  parameter int ITER = MD_DIV_ITER
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cancel,
  input  logic         signed_op,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(ITER + 1);

  logic          active;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic          neg_quo, neg_rem;
  logic [W:0]    shifted, trial;
  logic          fits;
  logic [W-1:0]  rem_n, quo_n;

  assign shifted = {rem_q, quo_q[W-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign fits    = ~trial[W];
  assign rem_n   = fits ? trial[W-1:0] : shifted[W-1:0];
  assign quo_n   = {quo_q[W-2:0], fits};

  // Result is presented combinationally in the last iteration so the
  // controller can capture it on the same edge it enters DONE.
  assign done      = active & (cnt == CW'(ITER - 1));
  assign quotient  = neg_quo ? -quo_n : quo_n;
  assign remainder = neg_rem ? -rem_n : rem_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (cancel) begin
      active <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= (signed_op & dividend[W-1]) ? -dividend : dividend;
      dvs_q   <= (signed_op & divisor[W-1]) ? -divisor : divisor;
      neg_quo <= signed_op & (dividend[W-1] ^ divisor[W-1]);
      neg_rem <= signed_op & dividend[W-1];
    end else if (active) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt   <= cnt + CW'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - E-stage MULT/MULTU/DIV/DIVU sequencer with stall and HI/LO write strobe
// Optional MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| finish in one cycle.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W   = MD_DATA_W,
  parameter int DIV_ITER = MD_DIV_ITER
) (
  input logic         clk,
  input logic         rst,
  muldiv_ctrl_if.slave md
);

  md_state_e             state_q, state_d;
  logic [DATA_W-1:0]     op_a_q, op_b_q;
  logic                  sgn_q;
  logic [DATA_W-1:0]     hi_q, lo_q;
  logic                  accept, div_zero, early_out;
  logic                  div_start, div_done;
  logic [DATA_W-1:0]     div_quo, div_rem;
  logic [2*DATA_W-1:0]   ext_a, ext_b, product;
  logic                  res_load;
  logic [DATA_W-1:0]     res_hi_d, res_lo_d;

  assign accept   = (state_q == MD_IDLE) & (md.ismultE | md.isdivE) & ~md.cancel;
  assign div_zero = (md.srcbE == '0);

`ifdef MULDIV_EARLY_OUT_EN
  logic [DATA_W-1:0] mag_a, mag_b;
  assign mag_a     = (md.signeddivE & md.srcaE[DATA_W-1]) ? -md.srcaE : md.srcaE;
  assign mag_b     = (md.signeddivE & md.srcbE[DATA_W-1]) ? -md.srcbE : md.srcbE;
  assign early_out = (mag_a < mag_b);
`else
  assign early_out = 1'b0;
`endif

  assign ext_a   = sgn_q ? {{DATA_W{op_a_q[DATA_W-1]}}, op_a_q} : {{DATA_W{1'b0}}, op_a_q};
  assign ext_b   = sgn_q ? {{DATA_W{op_b_q[DATA_W-1]}}, op_b_q} : {{DATA_W{1'b0}}, op_b_q};
  assign product = ext_a * ext_b;

  div_radix2 #(
    .W    (DATA_W),
    .ITER (DIV_ITER)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .cancel    (md.cancel),
    .signed_op (md.signeddivE),
    .dividend  (md.srcaE),
    .divisor   (md.srcbE),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    res_load  = 1'b0;
    res_hi_d  = hi_q;
    res_lo_d  = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          if (md.isdivE) begin
            if (div_zero) begin
              state_d  = MD_DONE;
              res_load = 1'b1;
              res_hi_d = md.srcaE;
              res_lo_d = '1;
            end else if (early_out) begin
              state_d  = MD_DONE;
              res_load = 1'b1;
              res_hi_d = md.srcaE;
              res_lo_d = '0;
            end else begin
              state_d   = MD_DIV;
              div_start = 1'b1;
            end
          end else begin
            state_d = MD_MULT;
          end
        end
      end
      MD_MULT: begin
        state_d              = MD_DONE;
        res_load             = 1'b1;
        {res_hi_d, res_lo_d} = product;
      end
      MD_DIV: begin
        if (div_done) begin
          state_d  = MD_DONE;
          res_load = 1'b1;
          res_hi_d = div_rem;
          res_lo_d = div_quo;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    // A flush drops the operation before any result reaches HI/LO.
    if (md.cancel) begin
      state_d   = MD_IDLE;
      res_load  = 1'b0;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
      sgn_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (accept) begin
        op_a_q <= md.srcaE;
        op_b_q <= md.srcbE;
        sgn_q  <= md.isdivE ? md.signeddivE : md.signedmultE;
      end
      if (res_load) begin
        hi_q <= res_hi_d;
        lo_q <= res_lo_d;
      end
    end
  end

  assign md.busy         = (state_q != MD_IDLE);
  assign md.stall_muldiv = ~rst & (accept | (state_q == MD_MULT) | (state_q == MD_DIV));
  assign md.hilo_we      = (state_q == MD_DONE) & ~md.cancel;
  assign md.hi_o         = hi_q;
  assign md.lo_o         = lo_q;

endmodule
